// File: rtl/reorder_buffer_if.sv
// reorder_buffer_if: issue, lookup, writeback and retire signals around the reorder buffer
interface reorder_buffer_if #(
    parameter int ROB_LOG = 4,
    parameter int DATA_W  = 32
);
    logic                rob_full;
    logic [ROB_LOG-1:0]  rob_free_idx;
    logic                de_in_en;
    logic [1:0]          de_type_in;
    logic [4:0]          de_rd_in;
    logic                de_pred_jump_in;
    logic [DATA_W-1:0]   de_alt_pc_in;
    logic [ROB_LOG-1:0]  de_qj_idx_in;
    logic [ROB_LOG-1:0]  de_qk_idx_in;
    logic                rob_qj_ready;
    logic                rob_qk_ready;
    logic [DATA_W-1:0]   rob_qj_val;
    logic [DATA_W-1:0]   rob_qk_val;
    logic                rs_in_en;
    logic [ROB_LOG-1:0]  rs_rob_idx_in;
    logic [DATA_W-1:0]   rs_val_in;
    logic                lsb_in_en;
    logic [ROB_LOG-1:0]  lsb_rob_idx_in;
    logic [DATA_W-1:0]   lsb_val_in;
    logic                commit_reg_en;
    logic [4:0]          commit_rd;
    logic [DATA_W-1:0]   commit_val;
    logic [ROB_LOG-1:0]  commit_rob_idx;
    logic                commit_store_en;
    logic                roll_back;
    logic [DATA_W-1:0]   roll_back_pc;

    modport master (
        input  rob_full, rob_free_idx, rob_qj_ready, rob_qk_ready, rob_qj_val, rob_qk_val,
               commit_reg_en, commit_rd, commit_val, commit_rob_idx, commit_store_en,
               roll_back, roll_back_pc,
        output de_in_en, de_type_in, de_rd_in, de_pred_jump_in, de_alt_pc_in,
               de_qj_idx_in, de_qk_idx_in, rs_in_en, rs_rob_idx_in, rs_val_in,
               lsb_in_en, lsb_rob_idx_in, lsb_val_in
    );

    modport slave (
        output rob_full, rob_free_idx, rob_qj_ready, rob_qk_ready, rob_qj_val, rob_qk_val,
               commit_reg_en, commit_rd, commit_val, commit_rob_idx, commit_store_en,
               roll_back, roll_back_pc,
        input  de_in_en, de_type_in, de_rd_in, de_pred_jump_in, de_alt_pc_in,
               de_qj_idx_in, de_qk_idx_in, rs_in_en, rs_rob_idx_in, rs_val_in,
               lsb_in_en, lsb_rob_idx_in, lsb_val_in
    );
endinterface

// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order ROB with CDB/LSB writeback, operand bypass and branch roll-back
module reorder_buffer #(
    parameter int ROB_LOG = 4,
    parameter int DATA_W  = 32
) (
    input logic              clk,
    input logic              rst_in,
    input logic              rdy_in,
    reorder_buffer_if.slave  rob
);
    localparam int ROB_SIZE = 1 << ROB_LOG;
    localparam logic [ROB_LOG:0] CAP    = (ROB_LOG+1)'(ROB_SIZE);
    localparam logic [ROB_LOG:0] ALMOST = (ROB_LOG+1)'(ROB_SIZE - 1);

    logic [ROB_SIZE-1:0] busy, ready;
    logic [1:0]          typ    [ROB_SIZE];
    logic [4:0]          rd_q   [ROB_SIZE];
    logic [DATA_W-1:0]   value  [ROB_SIZE];
    logic                pred   [ROB_SIZE];
    logic [DATA_W-1:0]   alt_pc [ROB_SIZE];
    logic [ROB_LOG-1:0]  head, tail;
    logic [ROB_LOG:0]    count;

    logic rs_ok, lsb_ok, do_issue, do_commit, is_branch, is_store, mispredict;

    // accept/commit decisions; traffic during a roll-back cycle is stale and dropped
    always_comb begin
        rs_ok      = rob.rs_in_en && busy[rob.rs_rob_idx_in] && !rob.roll_back;
        lsb_ok     = rob.lsb_in_en && busy[rob.lsb_rob_idx_in] && !rob.roll_back;
        do_issue   = rob.de_in_en && !rob.roll_back && count != CAP;
        do_commit  = busy[head] && ready[head];
        is_branch  = typ[head] == 2'b01;
        is_store   = typ[head] == 2'b10;
        mispredict = do_commit && is_branch && (value[head][0] != pred[head]);
        rob.rob_full     = count >= ALMOST;
        rob.rob_free_idx = tail;
    end

    // operand lookup for qj: same-cycle writeback bypass (LSB first), then stored value
    always_comb begin
        rob.rob_qj_ready = 1'b0;
        rob.rob_qj_val   = '0;
        if (lsb_ok && rob.lsb_rob_idx_in == rob.de_qj_idx_in) begin
            rob.rob_qj_ready = 1'b1;
            rob.rob_qj_val   = rob.lsb_val_in;
        end else if (rs_ok && rob.rs_rob_idx_in == rob.de_qj_idx_in) begin
            rob.rob_qj_ready = 1'b1;
            rob.rob_qj_val   = rob.rs_val_in;
        end else if (busy[rob.de_qj_idx_in] && ready[rob.de_qj_idx_in]) begin
            rob.rob_qj_ready = 1'b1;
            rob.rob_qj_val   = value[rob.de_qj_idx_in];
        end
    end

    // operand lookup for qk: same priority as qj
    always_comb begin
        rob.rob_qk_ready = 1'b0;
        rob.rob_qk_val   = '0;
        if (lsb_ok && rob.lsb_rob_idx_in == rob.de_qk_idx_in) begin
            rob.rob_qk_ready = 1'b1;
            rob.rob_qk_val   = rob.lsb_val_in;
        end else if (rs_ok && rob.rs_rob_idx_in == rob.de_qk_idx_in) begin
            rob.rob_qk_ready = 1'b1;
            rob.rob_qk_val   = rob.rs_val_in;
        end else if (busy[rob.de_qk_idx_in] && ready[rob.de_qk_idx_in]) begin
            rob.rob_qk_ready = 1'b1;
            rob.rob_qk_val   = value[rob.de_qk_idx_in];
        end
    end

    // entry state, pointers and registered retire pulses; a mispredict flushes everything
    always_ff @(posedge clk) begin
        if (rst_in) begin
            head                <= '0;
            tail                <= '0;
            count               <= '0;
            busy                <= '0;
            ready               <= '0;
            rob.commit_reg_en   <= 1'b0;
            rob.commit_rd       <= '0;
            rob.commit_val      <= '0;
            rob.commit_rob_idx  <= '0;
            rob.commit_store_en <= 1'b0;
            rob.roll_back       <= 1'b0;
            rob.roll_back_pc    <= '0;
        end else if (!rdy_in) begin
            rob.commit_reg_en   <= 1'b0;
            rob.commit_store_en <= 1'b0;
            rob.roll_back       <= 1'b0;
        end else begin
            rob.commit_reg_en   <= 1'b0;
            rob.commit_store_en <= 1'b0;
            rob.roll_back       <= 1'b0;
            if (rs_ok) begin
                ready[rob.rs_rob_idx_in] <= 1'b1;
                value[rob.rs_rob_idx_in] <= rob.rs_val_in;
            end
            if (lsb_ok) begin
                ready[rob.lsb_rob_idx_in] <= 1'b1;
                value[rob.lsb_rob_idx_in] <= rob.lsb_val_in;
            end
            if (do_issue) begin
                busy[tail]   <= 1'b1;
                ready[tail]  <= 1'b0;
                typ[tail]    <= rob.de_type_in;
                rd_q[tail]   <= rob.de_rd_in;
                pred[tail]   <= rob.de_pred_jump_in;
                alt_pc[tail] <= rob.de_alt_pc_in;
                tail         <= tail + ROB_LOG'(1);
            end
            if (do_commit) begin
                busy[head]          <= 1'b0;
                ready[head]         <= 1'b0;
                head                <= head + ROB_LOG'(1);
                rob.commit_rob_idx  <= head;
                rob.commit_rd       <= rd_q[head];
                rob.commit_val      <= value[head];
                rob.commit_reg_en   <= !is_branch && !is_store;
                rob.commit_store_en <= is_store;
                rob.roll_back       <= mispredict;
                if (mispredict)
                    rob.roll_back_pc <= alt_pc[head];
            end
            count <= count + (ROB_LOG+1)'(do_issue) - (ROB_LOG+1)'(do_commit);
            if (mispredict) begin
                busy  <= '0;
                ready <= '0;
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end
        end
    end
endmodule
